multicycle_controller: RTL and testbench

Moore-style multicycle control FSM that drives the Weihai MIPS datapath. It decodes the instruction fields the datapath presents and sequences each instruction through fetch, decode, execute, memory and write-back. It produces every datapath select and enable, plus the memory read/write strobes. It sits directly upstream of the datapath and the unified instruction/data memory.

---
 rtl/multicycle_controller_if.sv | 32 +++
 rtl/multicycle_controller.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the MIPS datapath.
// The master drives every select and strobe; the slave supplies the decoded instruction fields.
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic       iord;
    logic       pcen;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] memtoreg;
    logic [1:0] regdst;
    logic [1:0] pcsource;
    logic [1:0] alusrcb;
    logic [2:0] alucont;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output memread, memwrite, alusrca, iord, pcen, irwrite, regwrite,
               memtoreg, regdst, pcsource, alusrcb, alucont, state
    );

    modport slave (
        output op, funct, zero,
        input  memread, memwrite, alusrca, iord, pcen, irwrite, regwrite,
               memtoreg, regdst, pcsource, alusrcb, alucont, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore multicycle control FSM for the Weihai MIPS datapath: sequences fetch, decode,
// execute, memory and write-back, producing all datapath selects and memory strobes.
module multicycle_controller (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_controller_if.master       bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWR   = 4'd4,
        S_RTYPEEX = 4'd5,
        S_RTYPEWB = 4'd6,
        S_BEQEX   = 4'd7,
        S_JEX     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ITYPEWB = 4'd10,
        S_ORIEX   = 4'd11,
        S_LUIEX   = 4'd12,
        S_JALEX   = 4'd13,
        S_JREX    = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Bit 3 flags a supported R-type funct; bits 2:0 are the ALU control for it.
    function automatic logic [3:0] funct_decode(input logic [5:0] fn);
        logic [3:0] res;
        case (fn)
            6'b100000: res = 4'b1_010;
            6'b100010: res = 4'b1_110;
            6'b100100: res = 4'b1_000;
            6'b100101: res = 4'b1_001;
            6'b101010: res = 4'b1_111;
            default:   res = 4'b0_010;
        endcase
        return res;
    endfunction

    state_t     state_r;
    logic [3:0] fdec_s;

    logic       memread_s;
    logic       memwrite_s;
    logic       alusrca_s;
    logic       iord_s;
    logic       pcwrite_s;
    logic       branch_s;
    logic       irwrite_s;
    logic       regwrite_s;
    logic [1:0] memtoreg_s;
    logic [1:0] regdst_s;
    logic [1:0] pcsource_s;
    logic [1:0] alusrcb_s;
    logic [2:0] alucont_s;

    assign fdec_s = funct_decode(bus.funct);

    // State register and next-state sequencing; op/funct are consulted only from DECODE on.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            case (state_r)
                S_FETCH:  state_r <= S_DECODE;
                S_DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: state_r <= S_MEMADR;
                        OP_RTYPE:     state_r <= (bus.funct == FN_JR) ? S_JREX : S_RTYPEEX;
                        OP_BEQ:       state_r <= S_BEQEX;
                        OP_J:         state_r <= S_JEX;
                        OP_JAL:       state_r <= S_JALEX;
                        OP_ADDI:      state_r <= S_ADDIEX;
                        OP_ORI:       state_r <= S_ORIEX;
                        OP_LUI:       state_r <= S_LUIEX;
                        default:      state_r <= S_FETCH;
                    endcase
                end
                S_MEMADR:  state_r <= (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_RTYPEEX: state_r <= fdec_s[3] ? S_RTYPEWB : S_FETCH;
                S_ADDIEX, S_ORIEX, S_LUIEX: state_r <= S_ITYPEWB;
                default:   state_r <= S_FETCH;
            endcase
        end
    end

    // Per-state datapath controls, Moore decode with funct feeding the R-type ALU op.
    always_comb begin
        memread_s  = 1'b0;
        memwrite_s = 1'b0;
        alusrca_s  = 1'b0;
        iord_s     = 1'b0;
        pcwrite_s  = 1'b0;
        branch_s   = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        memtoreg_s = 2'b00;
        regdst_s   = 2'b00;
        pcsource_s = 2'b00;
        alusrcb_s  = 2'b00;
        alucont_s  = 3'b010;
        case (state_r)
            S_FETCH: begin
                memread_s = 1'b1;
                irwrite_s = 1'b1;
                alusrcb_s = 2'b01;
                pcwrite_s = 1'b1;
            end
            S_DECODE:  alusrcb_s = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
            end
            S_MEMRD: begin
                iord_s     = 1'b1;
                memread_s  = 1'b1;
                regwrite_s = 1'b1;
                memtoreg_s = 2'b01;
            end
            S_MEMWR: begin
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca_s = 1'b1;
                alucont_s = fdec_s[2:0];
            end
            S_RTYPEWB: begin
                regwrite_s = 1'b1;
                regdst_s   = 2'b01;
            end
            S_BEQEX: begin
                alusrca_s  = 1'b1;
                alucont_s  = 3'b110;
                branch_s   = 1'b1;
                pcsource_s = 2'b01;
            end
            S_JEX: begin
                pcwrite_s  = 1'b1;
                pcsource_s = 2'b10;
            end
            S_ORIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                alucont_s = 3'b001;
            end
            S_LUIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b11;
            end
            S_ITYPEWB: regwrite_s = 1'b1;
            S_JALEX: begin
                regwrite_s = 1'b1;
                regdst_s   = 2'b10;
                memtoreg_s = 2'b10;
                pcwrite_s  = 1'b1;
                pcsource_s = 2'b10;
            end
            S_JREX: begin
                pcwrite_s  = 1'b1;
                pcsource_s = 2'b11;
            end
            default: alucont_s = 3'b010;
        endcase
    end

    // Reset masks every state-changing strobe so an abandoned instruction cannot write.
    assign bus.memread  = memread_s  & ~reset;
    assign bus.memwrite = memwrite_s & ~reset;
    assign bus.irwrite  = irwrite_s  & ~reset;
    assign bus.regwrite = regwrite_s & ~reset;
    assign bus.pcen     = (pcwrite_s | (branch_s & bus.zero)) & ~reset;
    assign bus.alusrca  = alusrca_s;
    assign bus.iord     = iord_s;
    assign bus.memtoreg = memtoreg_s;
    assign bus.regdst   = regdst_s;
    assign bus.pcsource = pcsource_s;
    assign bus.alusrcb  = alusrcb_s;
    assign bus.alucont  = alucont_s;
    assign bus.state    = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through its
// state sequence and checks state and control outputs against hand-derived values.
module tb_multicycle_controller;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;
    int   fail_cnt;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [3:0] exp);
        check(tag, {4'h0, bus.state}, {4'h0, exp});
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        fail_cnt  = 0;
        reset     = 1'b1;
        bus.op    = 6'b000000;
        bus.funct = 6'b000000;
        bus.zero  = 1'b0;

        // power-up reset
        tick();
        tick();
        check_state("rst_state", 4'd0);
        check("rst_memread", {7'd0, bus.memread}, 8'd0);
        check("rst_pcen", {7'd0, bus.pcen}, 8'd0);
        check("rst_irwrite", {7'd0, bus.irwrite}, 8'd0);
        reset = 1'b0;
        #1;
        check("fetch_strobes", {4'd0, bus.memread, bus.irwrite, bus.pcen, bus.regwrite}, 8'b0000_1110);
        check("fetch_alusrcb", {6'd0, bus.alusrcb}, 8'd1);

        // lw: 0,1,2,3,0
        bus.op = 6'b100011;
        tick(); check_state("lw_s1", 4'd1);
        check("dec_alusrcb", {6'd0, bus.alusrcb}, 8'd3);
        tick(); check_state("lw_s2", 4'd2);
        check("memadr_src", {5'd0, bus.alusrca, bus.alusrcb}, 8'b0000_0110);
        tick(); check_state("lw_s3", 4'd3);
        check("memrd_ctl", {bus.iord, bus.regwrite, bus.memread, bus.memwrite, bus.memtoreg, bus.regdst},
              8'b1110_0100);
        tick(); check_state("lw_s0", 4'd0);

        // sw: 0,1,2,4,0
        bus.op = 6'b101011;
        tick(); check("sw_s1_memwrite", {4'd0, bus.state}, 8'd1);
        tick(); check("sw_s2_memwrite", {3'd0, bus.memwrite, bus.state}, 8'h02);
        tick(); check("sw_s4", {2'd0, bus.iord, bus.memwrite, bus.state}, 8'h34);
        check("sw_regwrite", {7'd0, bus.regwrite}, 8'd0);
        tick(); check("sw_s0", {3'd0, bus.memwrite, bus.state}, 8'h00);

        // R-type sub
        bus.op = 6'b000000; bus.funct = 6'b100010;
        tick(); check_state("sub_s1", 4'd1);
        tick(); check_state("sub_s5", 4'd5);
        check("sub_alucont", {4'd0, bus.alusrca, bus.alucont}, 8'b0000_1110);
        check("sub_ex_regwrite", {7'd0, bus.regwrite}, 8'd0);
        tick(); check_state("sub_s6", 4'd6);
        check("sub_wb", {5'd0, bus.regwrite, bus.regdst}, 8'b0000_0101);
        tick(); check_state("sub_s0", 4'd0);

        // R-type slt
        bus.funct = 6'b101010;
        tick(); tick(); check("slt_alucont", {1'b0, bus.alucont, bus.state}, 8'h75);
        tick(); check_state("slt_s6", 4'd6);
        tick();

        // beq: taken then not-taken in the same cycle
        bus.op = 6'b000100;
        tick(); tick(); check_state("beq_s7", 4'd7);
        bus.zero = 1'b1; #1;
        check("beq_taken", {3'd0, bus.pcen, bus.pcsource, 2'b00}, 8'b0001_0100);
        check("beq_alucont", {5'd0, bus.alucont}, 8'd6);
        bus.zero = 1'b0; #1;
        check("beq_not_taken", {7'd0, bus.pcen}, 8'd0);
        tick(); check_state("beq_s0", 4'd0);

        // reset from state 7 with zero high
        tick(); tick(); check_state("beq2_s7", 4'd7);
        bus.zero = 1'b1;
        reset = 1'b1; #1;
        check("rst7_strobes", {3'd0, bus.memread, bus.memwrite, bus.irwrite, bus.regwrite, bus.pcen}, 8'd0);
        tick(); check_state("rst7_c1", 4'd0);
        check("rst7_c1_strobes", {4'd0, bus.memread, bus.irwrite, bus.pcen, bus.regwrite}, 8'd0);
        tick(); check_state("rst7_c2", 4'd0);
        reset = 1'b0; bus.zero = 1'b0; #1;
        check("rst7_fetch", {4'd0, bus.memread, bus.irwrite, bus.pcen, bus.regwrite}, 8'b0000_1110);

        // jal
        bus.op = 6'b000011;
        tick(); tick(); check_state("jal_s13", 4'd13);
        check("jal_ctl", {bus.regwrite, bus.pcen, bus.regdst, bus.memtoreg, bus.pcsource}, 8'b1110_1010);
        tick(); check_state("jal_s0", 4'd0);

        // jr
        bus.op = 6'b000000; bus.funct = 6'b001000;
        tick(); tick(); check_state("jr_s14", 4'd14);
        check("jr_ctl", {4'd0, bus.regwrite, bus.pcen, bus.pcsource}, 8'b0000_0111);
        tick(); check_state("jr_s0", 4'd0);

        // j
        bus.op = 6'b000010;
        tick(); tick(); check("j_s8", {1'b0, bus.pcen, bus.pcsource, bus.state}, 8'h68);
        tick(); check_state("j_s0", 4'd0);

        // addi, ori, lui
        bus.op = 6'b001000;
        tick(); tick(); check("addi_s9", {1'b0, bus.alucont, bus.state}, 8'h29);
        check("addi_alusrcb", {6'd0, bus.alusrcb}, 8'd2);
        tick(); check("addi_wb", {1'b0, bus.regwrite, bus.regdst, bus.state}, 8'h4A);
        tick(); check_state("addi_s0", 4'd0);
        bus.op = 6'b001101;
        tick(); tick(); check("ori_s11", {1'b0, bus.alucont, bus.state}, 8'h1B);
        tick(); check_state("ori_s10", 4'd10);
        tick();
        bus.op = 6'b001111;
        tick(); tick(); check("lui_s12", {2'd0, bus.alusrcb, bus.state}, 8'h3C);
        check("lui_alucont", {5'd0, bus.alucont}, 8'd2);
        tick(); check_state("lui_s10", 4'd10);
        tick(); check_state("lui_s0", 4'd0);

        // undefined op
        bus.op = 6'b111111;
        tick(); check("undef_s1", {2'd0, bus.regwrite, bus.memwrite, bus.state}, 8'h01);
        tick(); check_state("undef_s0", 4'd0);

        // unsupported funct
        bus.op = 6'b000000; bus.funct = 6'b000000;
        tick(); tick(); check("badfn_s5", {3'd0, bus.regwrite, bus.state}, 8'h05);
        tick(); check("badfn_s0", {3'd0, bus.regwrite, bus.state}, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
